// File: rtl/mem_req_buffer.sv
// Decoupling buffer between the Memory151 cache/arbiter memory port and main memory.
// Optional MEM_REQ_BUF_BYPASS_EN forwards a request to an empty request queue in the same cycle.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 28
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif

module mem_req_buffer #(
  parameter int unsigned REQ_DEPTH  = 4,
  parameter int unsigned DATA_DEPTH = 8,
  parameter int unsigned LINE_BEATS = 4,
  parameter int unsigned MAX_RD     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_req_valid,
  output logic                         s_req_ready,
  input  logic                         s_req_rw,
  input  logic [`MEM_ADDR_BITS-1:0]    s_req_addr,
  input  logic [`MEM_TAG_BITS-1:0]     s_req_tag,
  input  logic                         s_data_valid,
  output logic                         s_data_ready,
  input  logic [`MEM_DATA_BITS-1:0]    s_data_bits,
  input  logic [`MEM_DATA_BITS/8-1:0]  s_data_mask,
  output logic                         m_req_valid,
  input  logic                         m_req_ready,
  output logic                         m_req_rw,
  output logic [`MEM_ADDR_BITS-1:0]    m_req_addr,
  output logic [`MEM_TAG_BITS-1:0]     m_req_tag,
  output logic                         m_data_valid,
  input  logic                         m_data_ready,
  output logic [`MEM_DATA_BITS-1:0]    m_data_bits,
  output logic [`MEM_DATA_BITS/8-1:0]  m_data_mask,
  input  logic                         mem_resp_valid,
  output logic [2:0]                   rd_outstanding,
  output logic                         err_resp_underflow
);

  localparam int unsigned AW  = `MEM_ADDR_BITS;
  localparam int unsigned TW  = `MEM_TAG_BITS;
  localparam int unsigned DW  = `MEM_DATA_BITS;
  localparam int unsigned MW  = `MEM_DATA_BITS / 8;
  localparam int unsigned RAW = $clog2(REQ_DEPTH);
  localparam int unsigned RCW = RAW + 1;
  localparam int unsigned DAW = $clog2(DATA_DEPTH);
  localparam int unsigned DCW = DAW + 1;
  localparam int unsigned CW  = $clog2(REQ_DEPTH * LINE_BEATS) + 1;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] bits;
    logic [MW-1:0] mask;
  } beat_t;

  // ---------------- request FIFO ----------------
  req_t             r_req_mem [REQ_DEPTH];
  logic [RAW-1:0]   r_req_wp;
  logic [RAW-1:0]   r_req_rp;
  logic [RCW-1:0]   r_req_cnt;
  logic             r_req_rdy;
  logic [RCW-1:0]   w_req_cnt_nxt;
  logic             w_req_push;
  logic             w_req_pop;
  logic             w_req_empty;
  logic             w_byp;
  logic             w_rd_ok;
  logic             w_mreq_hs;
  req_t             w_req_in;
  req_t             w_req_head;
  req_t             w_req_out;

  // ---------------- data FIFO ----------------
  beat_t            r_dat_mem [DATA_DEPTH];
  logic [DAW-1:0]   r_dat_wp;
  logic [DAW-1:0]   r_dat_rp;
  logic [DCW-1:0]   r_dat_cnt;
  logic             r_dat_rdy;
  logic [DCW-1:0]   w_dat_cnt_nxt;
  logic             w_dat_push;
  logic             w_dat_pop;
  beat_t            w_dat_in;
  beat_t            w_dat_head;

  // ---------------- accounting ----------------
  logic [CW-1:0]    r_wr_credit;
  logic [CW-1:0]    w_wr_credit_nxt;
  logic [2:0]       r_rd_out;
  logic [2:0]       w_rd_out_nxt;
  logic [1:0]       r_beat;
  logic [1:0]       w_beat_nxt;
  logic             r_err;
  logic             w_wr_issue;
  logic             w_rd_issue;
  logic             w_resp_ok;
  logic             w_underflow;
  logic             w_last_beat;

  assign w_req_in    = '{rw: s_req_rw, addr: s_req_addr, tag: s_req_tag};
  assign w_req_head  = r_req_mem[r_req_rp];
  assign w_req_empty = (r_req_cnt == '0);
  assign w_rd_ok     = (r_rd_out < 3'(MAX_RD));

`ifdef MEM_REQ_BUF_BYPASS_EN
  // Empty queue and ready sink: hand the upstream request straight through.
  assign w_byp     = w_req_empty && m_req_ready && s_req_valid && r_req_rdy &&
                     (s_req_rw || w_rd_ok);
  assign w_req_out = w_req_empty ? w_req_in : w_req_head;
  assign m_req_valid = w_req_empty ? w_byp : (w_req_head.rw || w_rd_ok);
`else
  assign w_byp       = 1'b0;
  assign w_req_out   = w_req_head;
  assign m_req_valid = !w_req_empty && (w_req_head.rw || w_rd_ok);
`endif

  assign m_req_rw    = w_req_out.rw;
  assign m_req_addr  = w_req_out.addr;
  assign m_req_tag   = w_req_out.tag;
  assign s_req_ready = r_req_rdy;

  assign w_mreq_hs  = m_req_valid && m_req_ready;
  assign w_req_push = s_req_valid && r_req_rdy && !w_byp;
  assign w_req_pop  = w_mreq_hs && !w_byp;

  always_comb begin
    w_req_cnt_nxt = r_req_cnt;
    case ({w_req_push, w_req_pop})
      2'b10:   w_req_cnt_nxt = r_req_cnt + RCW'(1);
      2'b01:   w_req_cnt_nxt = r_req_cnt - RCW'(1);
      default: w_req_cnt_nxt = r_req_cnt;
    endcase
  end

  // Ready is registered from next occupancy, so it never sees same-cycle pops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req_wp  <= '0;
      r_req_rp  <= '0;
      r_req_cnt <= '0;
      r_req_rdy <= 1'b0;
    end else begin
      if (w_req_push) r_req_wp <= r_req_wp + RAW'(1);
      if (w_req_pop)  r_req_rp <= r_req_rp + RAW'(1);
      r_req_cnt <= w_req_cnt_nxt;
      r_req_rdy <= (w_req_cnt_nxt != RCW'(REQ_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_push) r_req_mem[r_req_wp] <= w_req_in;
  end

  // ---------------- data FIFO ----------------
  assign w_dat_in     = '{bits: s_data_bits, mask: s_data_mask};
  assign w_dat_head   = r_dat_mem[r_dat_rp];
  assign s_data_ready = r_dat_rdy;
  assign m_data_valid = (r_dat_cnt != '0) && (r_wr_credit != '0);
  assign m_data_bits  = w_dat_head.bits;
  assign m_data_mask  = w_dat_head.mask;
  assign w_dat_push   = s_data_valid && r_dat_rdy;
  assign w_dat_pop    = m_data_valid && m_data_ready;

  always_comb begin
    w_dat_cnt_nxt = r_dat_cnt;
    case ({w_dat_push, w_dat_pop})
      2'b10:   w_dat_cnt_nxt = r_dat_cnt + DCW'(1);
      2'b01:   w_dat_cnt_nxt = r_dat_cnt - DCW'(1);
      default: w_dat_cnt_nxt = r_dat_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dat_wp  <= '0;
      r_dat_rp  <= '0;
      r_dat_cnt <= '0;
      r_dat_rdy <= 1'b0;
    end else begin
      if (w_dat_push) r_dat_wp <= r_dat_wp + DAW'(1);
      if (w_dat_pop)  r_dat_rp <= r_dat_rp + DAW'(1);
      r_dat_cnt <= w_dat_cnt_nxt;
      r_dat_rdy <= (w_dat_cnt_nxt != DCW'(DATA_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_dat_push) r_dat_mem[r_dat_wp] <= w_dat_in;
  end

  // ---------------- write credit: data only flows behind an issued write ----------------
  assign w_wr_issue = w_mreq_hs && m_req_rw;

  always_comb begin
    w_wr_credit_nxt = r_wr_credit;
    case ({w_wr_issue, w_dat_pop})
      2'b10:   w_wr_credit_nxt = r_wr_credit + CW'(LINE_BEATS);
      2'b01:   w_wr_credit_nxt = r_wr_credit - CW'(1);
      2'b11:   w_wr_credit_nxt = r_wr_credit + CW'(LINE_BEATS - 1);
      default: w_wr_credit_nxt = r_wr_credit;
    endcase
  end

  // ---------------- read accounting ----------------
  assign w_rd_issue  = w_mreq_hs && !m_req_rw;
  assign w_underflow = mem_resp_valid && (r_rd_out == 3'd0) && (r_beat == 2'd0);
  assign w_resp_ok   = mem_resp_valid && !w_underflow;
  assign w_last_beat = w_resp_ok && (r_beat == 2'(LINE_BEATS - 1));

  always_comb begin
    w_beat_nxt   = r_beat;
    w_rd_out_nxt = r_rd_out;
    if (w_resp_ok) w_beat_nxt = w_last_beat ? 2'd0 : r_beat + 2'd1;
    case ({w_rd_issue, w_last_beat})
      2'b10:   w_rd_out_nxt = r_rd_out + 3'd1;
      2'b01:   w_rd_out_nxt = r_rd_out - 3'd1;
      default: w_rd_out_nxt = r_rd_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_credit <= '0;
      r_rd_out    <= 3'd0;
      r_beat      <= 2'd0;
      r_err       <= 1'b0;
    end else begin
      r_wr_credit <= w_wr_credit_nxt;
      r_rd_out    <= w_rd_out_nxt;
      r_beat      <= w_beat_nxt;
      if (w_underflow) r_err <= 1'b1;
    end
  end

  assign rd_outstanding     = r_rd_out;
  assign err_resp_underflow = r_err;

endmodule

// File: tb/tb_mem_req_buffer.sv
// Directed self-checking bench for mem_req_buffer (default parameters).
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 28
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif

module tb_mem_req_buffer;

  logic                         clk;
  logic                         reset;
  logic                         s_req_valid;
  logic                         s_req_ready;
  logic                         s_req_rw;
  logic [`MEM_ADDR_BITS-1:0]    s_req_addr;
  logic [`MEM_TAG_BITS-1:0]     s_req_tag;
  logic                         s_data_valid;
  logic                         s_data_ready;
  logic [`MEM_DATA_BITS-1:0]    s_data_bits;
  logic [`MEM_DATA_BITS/8-1:0]  s_data_mask;
  logic                         m_req_valid;
  logic                         m_req_ready;
  logic                         m_req_rw;
  logic [`MEM_ADDR_BITS-1:0]    m_req_addr;
  logic [`MEM_TAG_BITS-1:0]     m_req_tag;
  logic                         m_data_valid;
  logic                         m_data_ready;
  logic [`MEM_DATA_BITS-1:0]    m_data_bits;
  logic [`MEM_DATA_BITS/8-1:0]  m_data_mask;
  logic                         mem_resp_valid;
  logic [2:0]                   rd_outstanding;
  logic                         err_resp_underflow;

  int n_chk;
  int n_fail;

  logic [`MEM_DATA_BITS-1:0]   beat_bits [5];
  logic [`MEM_DATA_BITS/8-1:0] beat_mask [5];

  mem_req_buffer dut (
    .clk                (clk),
    .reset              (reset),
    .s_req_valid        (s_req_valid),
    .s_req_ready        (s_req_ready),
    .s_req_rw           (s_req_rw),
    .s_req_addr         (s_req_addr),
    .s_req_tag          (s_req_tag),
    .s_data_valid       (s_data_valid),
    .s_data_ready       (s_data_ready),
    .s_data_bits        (s_data_bits),
    .s_data_mask        (s_data_mask),
    .m_req_valid        (m_req_valid),
    .m_req_ready        (m_req_ready),
    .m_req_rw           (m_req_rw),
    .m_req_addr         (m_req_addr),
    .m_req_tag          (m_req_tag),
    .m_data_valid       (m_data_valid),
    .m_data_ready       (m_data_ready),
    .m_data_bits        (m_data_bits),
    .m_data_mask        (m_data_mask),
    .mem_resp_valid     (mem_resp_valid),
    .rd_outstanding     (rd_outstanding),
    .err_resp_underflow (err_resp_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    s_req_valid    = 1'b0;
    s_req_rw       = 1'b0;
    s_req_addr     = '0;
    s_req_tag      = '0;
    s_data_valid   = 1'b0;
    s_data_bits    = '0;
    s_data_mask    = '0;
    m_req_ready    = 1'b0;
    m_data_ready   = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic drive_req(input logic rw, input logic [31:0] addr, input logic [7:0] tag);
    s_req_valid = 1'b1;
    s_req_rw    = rw;
    s_req_addr  = `MEM_ADDR_BITS'(addr);
    s_req_tag   = `MEM_TAG_BITS'(tag);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int j = 0; j < 5; j++) begin
      beat_bits[j] = {4{32'hA5000000 + 32'(j)}};
      beat_mask[j] = 16'hF0F0 ^ 16'(j * 16'h0111);
    end

    // Reset state
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_s_req_ready", 128'(s_req_ready), 128'd0);
    chk("rst_s_data_ready", 128'(s_data_ready), 128'd0);
    chk("rst_m_req_valid", 128'(m_req_valid), 128'd0);
    chk("rst_m_data_valid", 128'(m_data_valid), 128'd0);
    chk("rst_rd_out", 128'(rd_outstanding), 128'd0);
    chk("rst_err", 128'(err_resp_underflow), 128'd0);
    reset = 1'b1;
    tick();
    chk("rel_s_req_ready", 128'(s_req_ready), 128'd1);
    chk("rel_s_data_ready", 128'(s_data_ready), 128'd1);

    // Write ordering: data held until its write request issues
    m_data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive_req(1'b1, 32'h10, 8'd7);
      else s_req_valid = 1'b0;
      if (i < 4) begin
        s_data_valid = 1'b1;
        s_data_bits  = beat_bits[i];
        s_data_mask  = beat_mask[i];
      end else begin
        s_data_valid = 1'b0;
      end
      tick();
      chk("wr_hold_data", 128'(m_data_valid), 128'd0);
    end
    chk("wr_req_valid", 128'(m_req_valid), 128'd1);
    chk("wr_req_addr", 128'(m_req_addr), 128'h10);
    chk("wr_req_rw", 128'(m_req_rw), 128'd1);
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0;
    chk("wr_req_gone", 128'(m_req_valid), 128'd0);
    for (int j = 0; j < 4; j++) begin
      chk("wr_beat_valid", 128'(m_data_valid), 128'd1);
      chk("wr_beat_bits", 128'(m_data_bits), 128'(beat_bits[j]));
      chk("wr_beat_mask", 128'(m_data_mask), 128'(beat_mask[j]));
      tick();
    end
    chk("wr_drained", 128'(m_data_valid), 128'd0);
    s_data_valid = 1'b1;
    s_data_bits  = beat_bits[4];
    s_data_mask  = beat_mask[4];
    tick();
    s_data_valid = 1'b0;
    chk("wr_credit_zero", 128'(m_data_valid), 128'd0);
    tick();
    chk("wr_credit_zero2", 128'(m_data_valid), 128'd0);

    // Read cap at two outstanding lines
    do_reset();
    m_req_ready = 1'b1;
    drive_req(1'b0, 32'h1, 8'd1);
    tick();
    chk("rd_t1_valid", 128'(m_req_valid), 128'd1);
    chk("rd_t1_tag", 128'(m_req_tag), 128'd1);
    drive_req(1'b0, 32'h2, 8'd2);
    tick();
    chk("rd_out_1", 128'(rd_outstanding), 128'd1);
    chk("rd_t2_valid", 128'(m_req_valid), 128'd1);
    chk("rd_t2_tag", 128'(m_req_tag), 128'd2);
    drive_req(1'b0, 32'h3, 8'd3);
    tick();
    s_req_valid = 1'b0;
    chk("rd_out_2", 128'(rd_outstanding), 128'd2);
    chk("rd_t3_held", 128'(m_req_valid), 128'd0);
    tick();
    chk("rd_t3_held2", 128'(m_req_valid), 128'd0);
    mem_resp_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      tick();
      chk("rd_beats_partial", 128'(rd_outstanding), 128'd2);
    end
    tick();
    mem_resp_valid = 1'b0;
    chk("rd_out_after_line", 128'(rd_outstanding), 128'd1);
    chk("rd_t3_valid", 128'(m_req_valid), 128'd1);
    chk("rd_t3_tag", 128'(m_req_tag), 128'd3);
    tick();
    m_req_ready = 1'b0;
    chk("rd_out_back_2", 128'(rd_outstanding), 128'd2);
    chk("rd_queue_empty", 128'(m_req_valid), 128'd0);

    // Read handshake coinciding with the final response beat
    mem_resp_valid = 1'b1;
    drive_req(1'b0, 32'h4, 8'd4);
    tick();
    s_req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("sim_rd_out_1", 128'(rd_outstanding), 128'd1);
    tick();
    tick();
    tick();
    chk("sim_pre_rd_out", 128'(rd_outstanding), 128'd1);
    chk("sim_t4_valid", 128'(m_req_valid), 128'd1);
    chk("sim_t4_tag", 128'(m_req_tag), 128'd4);
    m_req_ready = 1'b1;
    tick();
    m_req_ready    = 1'b0;
    mem_resp_valid = 1'b0;
    chk("sim_rd_out_same", 128'(rd_outstanding), 128'd1);
    chk("sim_t4_gone", 128'(m_req_valid), 128'd0);

    // Underflow is sticky until reset
    do_reset();
    chk("uf_clear", 128'(err_resp_underflow), 128'd0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    chk("uf_set", 128'(err_resp_underflow), 128'd1);
    chk("uf_rd_out", 128'(rd_outstanding), 128'd0);
    tick();
    tick();
    chk("uf_sticky", 128'(err_resp_underflow), 128'd1);
    do_reset();
    chk("uf_reset", 128'(err_resp_underflow), 128'd0);

    // Full request FIFO
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, 32'h100 + 32'(i), 8'(i));
      tick();
    end
    chk("full_ready_low", 128'(s_req_ready), 128'd0);
    drive_req(1'b1, 32'h104, 8'd4);
    tick();
    chk("full_ready_low2", 128'(s_req_ready), 128'd0);
    chk("full_head_tag", 128'(m_req_tag), 128'd0);
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0;
    chk("full_ready_back", 128'(s_req_ready), 128'd1);
    tick();
    s_req_valid = 1'b0;
    chk("full_again", 128'(s_req_ready), 128'd0);
    m_req_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("full_drain_valid", 128'(m_req_valid), 128'd1);
      chk("full_drain_tag", 128'(m_req_tag), 128'(i));
      chk("full_drain_addr", 128'(m_req_addr), 128'h100 + 128'(i));
      tick();
    end
    m_req_ready = 1'b0;
    chk("full_drained", 128'(m_req_valid), 128'd0);

    // Reset mid-operation
    do_reset();
    m_req_ready = 1'b1;
    drive_req(1'b0, 32'h9, 8'd9);
    tick();
    tick();
    m_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1, 32'h200 + 32'(i), 8'(10 + i));
      s_data_valid = (i == 0);
      tick();
    end
    s_req_valid  = 1'b0;
    s_data_valid = 1'b0;
    chk("mid_rd_out_pre", 128'(rd_outstanding), 128'd1);
    chk("mid_valid_pre", 128'(m_req_valid), 128'd1);
    reset = 1'b0;
    tick();
    chk("mid_m_req_valid", 128'(m_req_valid), 128'd0);
    chk("mid_m_data_valid", 128'(m_data_valid), 128'd0);
    chk("mid_rd_out", 128'(rd_outstanding), 128'd0);
    chk("mid_s_req_ready", 128'(s_req_ready), 128'd0);
    chk("mid_err", 128'(err_resp_underflow), 128'd0);
    reset = 1'b1;
    tick();
    chk("mid_rel_ready", 128'(s_req_ready), 128'd1);
    chk("mid_rel_empty", 128'(m_req_valid), 128'd0);
    m_req_ready = 1'b1;
    drive_req(1'b0, 32'h20, 8'd1);
    #1;
`ifdef MEM_REQ_BUF_BYPASS_EN
    chk("lat_same_cycle", 128'(m_req_valid), 128'd1);
    chk("lat_same_addr", 128'(m_req_addr), 128'h20);
    tick();
    s_req_valid = 1'b0;
    chk("lat_rd_out", 128'(rd_outstanding), 128'd1);
    chk("lat_not_queued", 128'(m_req_valid), 128'd0);
`else
    chk("lat_no_bypass", 128'(m_req_valid), 128'd0);
    tick();
    s_req_valid = 1'b0;
    chk("lat_next_valid", 128'(m_req_valid), 128'd1);
    chk("lat_next_addr", 128'(m_req_addr), 128'h20);
    chk("lat_rd_out_0", 128'(rd_outstanding), 128'd0);
    tick();
    chk("lat_rd_out", 128'(rd_outstanding), 128'd1);
    chk("lat_issued", 128'(m_req_valid), 128'd0);
`endif
    m_req_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
